// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_ctrl
// Purpose  : Decode-stage hazard and branch controller for the 5-stage RV64
//            pipeline. Tracks destinations in flight in EX/MEM/WB and drives
//            stall, bubble, IF/ID flush and PC redirect for the early
//            (decode-stage) branch unit. Keeps saturating stall / taken-branch
//            counters for bring-up.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            hold                  - global freeze (memory wait)
//            id_*                  - decode-stage instruction fields
//            stall, bubble         - hold PC+IF/ID, inject NOP into ID/EX
//            flush_ifid, pc_sel    - taken-branch redirect controls
//            branch_target         - redirect address (pass-through)
//            stall_count,
//            taken_count           - saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module id_hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_is_branch,
  input  logic             id_branch_ne,
  input  logic             id_equal,
  input  logic [PC_W-1:0]  id_branch_addr,
  output logic             stall,
  output logic             bubble,
  output logic             flush_ifid,
  output logic             pc_sel,
  output logic [PC_W-1:0]  branch_target,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Scoreboard. The load flag only matters while the producer sits in EX
  // (load-use), so MEM and WB keep just valid / rd / write-enable.
  logic       r_ex_v,  r_ex_wr,  r_ex_ld;
  logic [4:0] r_ex_rd;
  logic       r_mem_v, r_mem_wr;
  logic [4:0] r_mem_rd;
  logic       r_wb_v,  r_wb_wr;
  logic [4:0] r_wb_rd;

  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_taken_count;

  // A source matches a stage only if it is really read, is not x0, and the
  // stage holds a valid instruction that writes a non-zero rd.
  function automatic logic src_match(input logic       use_src,
                                     input logic [4:0] rs,
                                     input logic       v,
                                     input logic       wr,
                                     input logic [4:0] rd);
    return use_src & (rs != 5'd0) & v & wr & (rd != 5'd0) & (rs == rd);
  endfunction

  logic w_rs1_ex, w_rs1_mem, w_rs1_wb;
  logic w_rs2_ex, w_rs2_mem, w_rs2_wb;
  logic w_load_use, w_branch_hz, w_hz, w_taken;

  always_comb begin
    w_rs1_ex  = src_match(id_use_rs1, id_rs1, r_ex_v,  r_ex_wr,  r_ex_rd);
    w_rs1_mem = src_match(id_use_rs1, id_rs1, r_mem_v, r_mem_wr, r_mem_rd);
    w_rs1_wb  = src_match(id_use_rs1, id_rs1, r_wb_v,  r_wb_wr,  r_wb_rd);
    w_rs2_ex  = src_match(id_use_rs2, id_rs2, r_ex_v,  r_ex_wr,  r_ex_rd);
    w_rs2_mem = src_match(id_use_rs2, id_rs2, r_mem_v, r_mem_wr, r_mem_rd);
    w_rs2_wb  = src_match(id_use_rs2, id_rs2, r_wb_v,  r_wb_wr,  r_wb_rd);

    // Non-branch ops get EX/MEM forwarding, so only a load in EX hurts them.
    w_load_use  = id_valid & ~id_is_branch & r_ex_ld & (w_rs1_ex | w_rs2_ex);
    // The decode comparator has no forwarding, and a WB write is not yet
    // readable from the register file in the same cycle, so a branch waits
    // for its producers to drain out of all three stages.
    w_branch_hz = id_valid & id_is_branch &
                  (w_rs1_ex | w_rs1_mem | w_rs1_wb |
                   w_rs2_ex | w_rs2_mem | w_rs2_wb);
    w_hz        = w_load_use | w_branch_hz;
    w_taken     = id_valid & id_is_branch & ~w_hz & ~hold &
                  (id_equal ^ id_branch_ne);
  end

  // Control outputs are forced low while in reset.
  assign stall         = ~rst & (hold | w_hz);
  assign bubble        = ~rst & w_hz & ~hold;
  assign flush_ifid    = ~rst & w_taken;
  assign pc_sel        = ~rst & w_taken;
  assign branch_target = id_branch_addr;
  assign stall_count   = r_stall_count;
  assign taken_count   = r_taken_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_v        <= 1'b0;
      r_ex_wr       <= 1'b0;
      r_ex_ld       <= 1'b0;
      r_ex_rd       <= 5'd0;
      r_mem_v       <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_rd      <= 5'd0;
      r_wb_v        <= 1'b0;
      r_wb_wr       <= 1'b0;
      r_wb_rd       <= 5'd0;
      r_stall_count <= '0;
      r_taken_count <= '0;
    end else if (!hold) begin
      r_wb_v   <= r_mem_v;
      r_wb_wr  <= r_mem_wr;
      r_wb_rd  <= r_mem_rd;
      r_mem_v  <= r_ex_v;
      r_mem_wr <= r_ex_wr;
      r_mem_rd <= r_ex_rd;
      // A stalled instruction stays in IF/ID; EX receives an invalid slot.
      r_ex_v   <= id_valid & ~w_hz;
      r_ex_wr  <= id_regwrite;
      r_ex_ld  <= id_memread;
      r_ex_rd  <= id_rd;
      if (w_hz && (r_stall_count != c_cnt_max)) begin
        r_stall_count <= r_stall_count + c_cnt_one;
      end
      if (w_taken && (r_taken_count != c_cnt_max)) begin
        r_taken_count <= r_taken_count + c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_hazard_ctrl
// Purpose  : Self-checking bench for id_hazard_ctrl. A list-of-in-flight-
//            instructions model predicts every output each cycle; directed
//            scenarios add hand-computed literal expectations. A second,
//            narrow-counter instance shares the stimulus so counter
//            saturation is reached within a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam int SAT_W = 4;
  localparam int PC_W  = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            hold = 1'b0;
  logic            id_valid = 1'b0;
  logic [4:0]      id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic            id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic            id_regwrite = 1'b0, id_memread = 1'b0;
  logic            id_is_branch = 1'b0, id_branch_ne = 1'b0, id_equal = 1'b0;
  logic [PC_W-1:0] id_branch_addr = '0;

  logic             stall, bubble, flush_ifid, pc_sel;
  logic [PC_W-1:0]  branch_target;
  logic [CNT_W-1:0] stall_count, taken_count;

  logic             s_stall, s_bubble, s_flush_ifid, s_pc_sel;
  logic [PC_W-1:0]  s_branch_target;
  logic [SAT_W-1:0] s_stall_count, s_taken_count;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_is_branch(id_is_branch), .id_branch_ne(id_branch_ne),
    .id_equal(id_equal), .id_branch_addr(id_branch_addr),
    .stall(stall), .bubble(bubble), .flush_ifid(flush_ifid),
    .pc_sel(pc_sel), .branch_target(branch_target),
    .stall_count(stall_count), .taken_count(taken_count)
  );

  id_hazard_ctrl #(.CNT_W(SAT_W), .PC_W(PC_W)) dut_sat (
    .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_is_branch(id_is_branch), .id_branch_ne(id_branch_ne),
    .id_equal(id_equal), .id_branch_addr(id_branch_addr),
    .stall(s_stall), .bubble(s_bubble), .flush_ifid(s_flush_ifid),
    .pc_sel(s_pc_sel), .branch_target(s_branch_target),
    .stall_count(s_stall_count), .taken_count(s_taken_count)
  );

  // ---------------- behavioural model ----------------
  // in_flight[0] is the instruction issued most recently (now in EX),
  // [1] the one before (MEM), [2] the oldest still visible (WB).
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ent_t;

  ent_t in_flight [3];
  int   m_stall_n = 0;
  int   m_taken_n = 0;
  int   checks    = 0;
  int   failures  = 0;
  bit   started   = 1'b0;

  function automatic bit produces(int age, logic [4:0] r);
    return in_flight[age].v && in_flight[age].wr &&
           in_flight[age].rd != 5'd0 && in_flight[age].rd == r;
  endfunction

  function automatic void model_eval(output bit hz, output bit tk);
    logic [4:0] src [2];
    bit         used [2];
    bit         depends;
    bit         on_load;
    src[0]  = id_rs1;     src[1]  = id_rs2;
    used[0] = id_use_rs1; used[1] = id_use_rs2;
    depends = 1'b0;
    on_load = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (used[s] && src[s] != 5'd0) begin
        for (int age = 0; age < 3; age++) begin
          if (produces(age, src[s])) begin
            depends = 1'b1;
            if (age == 0 && in_flight[0].ld) on_load = 1'b1;
          end
        end
      end
    end
    hz = id_valid && (id_is_branch ? depends : on_load);
    tk = id_valid && id_is_branch && !hz && !hold && (id_equal != id_branch_ne);
  endfunction

  function automatic logic [63:0] sat(int n, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (longint'(n) > mx) ? mx : longint'(n);
  endfunction

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model state advances on the same edge as the DUT.
  always @(posedge clk) begin
    bit hz, tk;
    if (rst) begin
      for (int i = 0; i < 3; i++) in_flight[i] = '0;
      m_stall_n = 0;
      m_taken_n = 0;
    end else if (!hold) begin
      model_eval(hz, tk);
      if (hz) m_stall_n++;
      if (tk) m_taken_n++;
      in_flight[2] = in_flight[1];
      in_flight[1] = in_flight[0];
      in_flight[0] = {id_valid && !hz, id_rd, id_regwrite, id_memread};
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    bit hz, tk;
    if (started) begin
      model_eval(hz, tk);
      chk("stall",         stall,         !rst && (hold || hz));
      chk("bubble",        bubble,        !rst && hz && !hold);
      chk("flush_ifid",    flush_ifid,    !rst && tk);
      chk("pc_sel",        pc_sel,        !rst && tk);
      chk("branch_target", branch_target, id_branch_addr);
      chk("stall_count",   stall_count,   sat(m_stall_n, CNT_W));
      chk("taken_count",   taken_count,   sat(m_taken_n, CNT_W));
      chk("sat_stall",     s_stall,       !rst && (hold || hz));
      chk("sat_stall_cnt", s_stall_count, sat(m_stall_n, SAT_W));
      chk("sat_taken_cnt", s_taken_count, sat(m_taken_n, SAT_W));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_regwrite = 0; id_memread = 0; id_is_branch = 0;
    id_branch_ne = 0; id_equal = 0; id_branch_addr = '0;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input bit u1,
                           input logic [4:0] rs2, input bit u2,
                           input logic [4:0] rd, input bit rw, input bit mr,
                           input bit br, input bit ne, input bit eq,
                           input logic [PC_W-1:0] addr);
    id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; id_is_branch = br;
    id_branch_ne = ne; id_equal = eq; id_branch_addr = addr;
  endtask

  task automatic do_reset();
    rst = 1; hold = 0; set_nop();
    cyc(); cyc();
    rst = 0;
  endtask

  initial begin
    // Reset with hold and a would-be-taken branch on the inputs.
    rst = 1; hold = 1;
    set_instr(5'd5, 1, 5'd6, 1, 5'd7, 1, 1, 1, 0, 1, 12'h055);
    cyc();
    started = 1'b1;
    #2;
    chk("rst_stall",  stall, 0);
    chk("rst_bubble", bubble, 0);
    chk("rst_flush",  flush_ifid, 0);
    chk("rst_pc_sel", pc_sel, 0);
    cyc(); #2;
    chk("rst_stall_cnt", stall_count, 0);
    chk("rst_taken_cnt", taken_count, 0);
    rst = 0; hold = 0;
    set_instr(5'd3, 1, 5'd4, 1, 5'd0, 0, 0, 1, 0, 0, 12'h010);
    #2;
    chk("post_rst_stall", stall, 0);
    cyc(); set_nop();

    // Load-use: lw x5 ; add x6,x5,x7
    do_reset();
    set_instr(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, '0);
    cyc();
    set_instr(5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, 0, 0, '0);
    #2;
    chk("lu_stall",  stall, 1);
    chk("lu_bubble", bubble, 1);
    cyc(); #2;
    chk("lu_issue_stall", stall, 0);
    chk("lu_stall_cnt",   stall_count, 1);
    cyc(); set_nop();

    // Branch after ALU: add x3 ; beq x3,x4 (taken, target 0x1A4)
    do_reset();
    set_instr(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 0, '0);
    cyc();
    set_instr(5'd3, 1, 5'd4, 1, 5'd0, 0, 0, 1, 0, 1, 12'h1A4);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("br_stall", stall, 1);
      chk("br_no_redirect", pc_sel, 0);
      cyc();
    end
    #2;
    chk("br_pc_sel", pc_sel, 1);
    chk("br_flush",  flush_ifid, 1);
    chk("br_target", branch_target, 12'h1A4);
    chk("br_issue_stall", stall, 0);
    cyc(); set_nop(); #2;
    chk("br_pc_sel_once", pc_sel, 0);
    chk("br_taken_cnt",   taken_count, 1);
    chk("br_stall_cnt",   stall_count, 3);
    chk("model_br_taken", m_taken_n, 1);
    chk("model_br_stall", m_stall_n, 3);

    // x0 producer and bne
    do_reset();
    set_instr(5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0, 0, 0, '0);
    cyc();
    set_instr(5'd0, 1, 5'd1, 1, 5'd0, 0, 0, 1, 1, 1, 12'h222);
    #2;
    chk("x0_stall",     stall, 0);
    chk("bne_eq_pcsel", pc_sel, 0);
    cyc();
    id_equal = 0;
    #2;
    chk("bne_ne_pcsel", pc_sel, 1);
    chk("bne_ne_stall", stall, 0);
    cyc(); set_nop();

    // hold during a load-use hazard
    do_reset();
    set_instr(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, '0);
    cyc();
    set_instr(5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, 0, 0, '0);
    hold = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("hold_stall",  stall, 1);
      chk("hold_bubble", bubble, 0);
      chk("hold_cnt",    stall_count, 0);
      cyc();
    end
    hold = 0;
    #2;
    chk("unhold_bubble", bubble, 1);
    cyc(); #2;
    chk("unhold_issue", stall, 0);
    chk("unhold_cnt",   stall_count, 1);
    cyc(); set_nop();

    // Saturation of the narrow instance: 18 load-use hazards.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      set_instr(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, '0);
      cyc();
      set_instr(5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 0, '0);
      cyc(); cyc();
    end
    set_nop(); #2;
    chk("sat_wide_cnt",   stall_count, 18);
    chk("sat_narrow_cnt", s_stall_count, 4'hF);
    chk("model_sat_n",    m_stall_n, 18);

    // Randomized run, small register range to make dependencies common.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      hold = ($urandom_range(0, 7) == 0);
      id_valid       = ($urandom_range(0, 9) != 0);
      id_rs1         = 5'($urandom_range(0, 3));
      id_rs2         = 5'($urandom_range(0, 3));
      id_use_rs1     = 1'($urandom_range(0, 1));
      id_use_rs2     = 1'($urandom_range(0, 1));
      id_rd          = 5'($urandom_range(0, 3));
      id_regwrite    = ($urandom_range(0, 3) != 0);
      id_memread     = ($urandom_range(0, 2) == 0);
      id_is_branch   = ($urandom_range(0, 2) == 0);
      id_branch_ne   = 1'($urandom_range(0, 1));
      id_equal       = 1'($urandom_range(0, 1));
      id_branch_addr = PC_W'($urandom);
      cyc();
    end
    rst = 0; hold = 0; set_nop();
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
